// File: rtl/maze_step_controller.sv
// maze_step_controller
//   Sequences one agent action at a time against the maze map memory.
//   Computes the candidate cell with a boundary check, reads the cell code
//   when the move stays on the grid, and reports the resulting state,
//   reward and episode-termination status. Owns the agent position, the
//   per-episode step count and the completed-episode count.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   act_valid/ready action handshake; act is one-hot {right,left,down,up}
//   map_rd_en       read strobe to map memory, map_addr = row*GRID_W+col
//   map_rd_data     cell code, valid the cycle after map_rd_en
//   resp_valid      one-cycle pulse, step result valid
//   state           current agent state
//   next_state      resulting state of last step (held until next result)
//   reward          signed reward of last step
//   done/done_cause episode ended by last step; 0 none 1 goal 2 trap 3 timeout
//   step_count      steps taken in current episode
//   episode_count   completed episodes (wrapping)
module maze_step_controller #(
  parameter int unsigned       GRID_W      = 5,
  parameter int unsigned       GRID_H      = 5,
  parameter int unsigned       START_STATE = 0,
  parameter int unsigned       MAX_STEPS   = 50,
  parameter logic signed [7:0] R_STEP      = -8'sd1,
  parameter logic signed [7:0] R_WALL      = -8'sd5,
  parameter logic signed [7:0] R_GOAL      = 8'sd10,
  parameter logic signed [7:0] R_TRAP      = -8'sd10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        act_valid,
  output logic        act_ready,
  input  logic [3:0]  act,
  output logic        map_rd_en,
  output logic [6:0]  map_addr,
  input  logic [3:0]  map_rd_data,
  output logic        resp_valid,
  output logic [6:0]  state,
  output logic [6:0]  next_state,
  output logic [7:0]  reward,
  output logic        done,
  output logic [1:0]  done_cause,
  output logic [7:0]  step_count,
  output logic [15:0] episode_count
);

  // Start row/col are elaboration-time constants, so no hardware divider.
  localparam logic [6:0] W7        = 7'(GRID_W);
  localparam logic [6:0] LAST_ROW  = 7'(GRID_H - 1);
  localparam logic [6:0] LAST_COL  = 7'(GRID_W - 1);
  localparam logic [6:0] START_ST  = 7'(START_STATE);
  localparam logic [6:0] START_ROW = 7'(START_STATE / GRID_W);
  localparam logic [6:0] START_COL = 7'(START_STATE % GRID_W);
  localparam logic [7:0] MAX_ST    = 8'(MAX_STEPS);

  typedef enum logic [2:0] {IDLE, CHECK, READ, WAIT, RESP} fsm_e;

  fsm_e        fsm_q, fsm_d;
  logic [3:0]  act_q, act_d;
  logic [6:0]  row_q, row_d, col_q, col_d, state_q, state_d;
  logic [6:0]  cand_row_q, cand_row_d, cand_col_q, cand_col_d;
  logic [6:0]  addr_q, addr_d;
  logic [6:0]  ns_q, ns_d, ns_row_q, ns_row_d, ns_col_q, ns_col_d;
  logic [7:0]  reward_q, reward_d;
  logic        done_q, done_d;
  logic [1:0]  cause_q, cause_d;
  logic [7:0]  step_q, step_d;
  logic [15:0] epi_q, epi_d;

  // Candidate cell for the captured action. Address is derived from the
  // current state by +/-1 or +/-GRID_W rather than a multiply.
  logic       oob;
  logic [6:0] c_row, c_col, c_addr;

  always_comb begin
    oob    = 1'b0;
    c_row  = row_q;
    c_col  = col_q;
    c_addr = state_q;
    case (act_q)
      4'b0001: begin
        if (row_q == '0) oob = 1'b1;
        else begin
          c_row  = row_q - 7'd1;
          c_addr = state_q - W7;
        end
      end
      4'b0010: begin
        if (row_q == LAST_ROW) oob = 1'b1;
        else begin
          c_row  = row_q + 7'd1;
          c_addr = state_q + W7;
        end
      end
      4'b0100: begin
        if (col_q == '0) oob = 1'b1;
        else begin
          c_col  = col_q - 7'd1;
          c_addr = state_q - 7'd1;
        end
      end
      4'b1000: begin
        if (col_q == LAST_COL) oob = 1'b1;
        else begin
          c_col  = col_q + 7'd1;
          c_addr = state_q + 7'd1;
        end
      end
      default: oob = 1'b1; // not one-hot
    endcase
  end

  // Step result is latched on the edge entering RESP, from either the
  // short path (CHECK) or the map path (WAIT).
  logic       res_load, res_move;
  logic [7:0] res_reward;
  logic [1:0] res_cause;
  logic [7:0] new_cnt;

  always_comb begin
    fsm_d      = fsm_q;
    act_d      = act_q;
    row_d      = row_q;
    col_d      = col_q;
    state_d    = state_q;
    cand_row_d = cand_row_q;
    cand_col_d = cand_col_q;
    addr_d     = addr_q;
    ns_d       = ns_q;
    ns_row_d   = ns_row_q;
    ns_col_d   = ns_col_q;
    reward_d   = reward_q;
    done_d     = done_q;
    cause_d    = cause_q;
    step_d     = step_q;
    epi_d      = epi_q;
    res_load   = 1'b0;
    res_move   = 1'b0;
    res_reward = R_WALL;
    res_cause  = 2'd0;
    new_cnt    = step_q + 8'd1;

    case (fsm_q)
      IDLE: begin
        if (act_valid) begin
          act_d = act;
          fsm_d = CHECK;
        end
      end
      CHECK: begin
        if (oob) begin
          res_load = 1'b1;
        end else begin
          cand_row_d = c_row;
          cand_col_d = c_col;
          addr_d     = c_addr;
          fsm_d      = READ;
        end
      end
      READ: fsm_d = WAIT;
      WAIT: begin
        res_load = 1'b1;
        case (map_rd_data)
          4'd1: res_reward = R_WALL;
          4'd2: begin
            res_move   = 1'b1;
            res_reward = R_GOAL;
            res_cause  = 2'd1;
          end
          4'd3: begin
            res_move   = 1'b1;
            res_reward = R_TRAP;
            res_cause  = 2'd2;
          end
          default: begin
            res_move   = 1'b1;
            res_reward = R_STEP;
          end
        endcase
      end
      RESP: begin
        if (done_q) begin
          state_d = START_ST;
          row_d   = START_ROW;
          col_d   = START_COL;
          step_d  = '0;
          epi_d   = epi_q + 16'd1;
        end else begin
          state_d = ns_q;
          row_d   = ns_row_q;
          col_d   = ns_col_q;
          step_d  = new_cnt;
        end
        fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase

    if (res_load) begin
      fsm_d    = RESP;
      reward_d = res_reward;
      if (res_move) begin
        ns_d     = addr_q;
        ns_row_d = cand_row_q;
        ns_col_d = cand_col_q;
      end else begin
        ns_d     = state_q;
        ns_row_d = row_q;
        ns_col_d = col_q;
      end
      // Goal/trap outrank timeout on the same step.
      if (res_cause != 2'd0) begin
        done_d  = 1'b1;
        cause_d = res_cause;
      end else if (new_cnt == MAX_ST) begin
        done_d  = 1'b1;
        cause_d = 2'd3;
      end else begin
        done_d  = 1'b0;
        cause_d = 2'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q      <= IDLE;
      act_q      <= '0;
      row_q      <= START_ROW;
      col_q      <= START_COL;
      state_q    <= START_ST;
      cand_row_q <= START_ROW;
      cand_col_q <= START_COL;
      addr_q     <= '0;
      ns_q       <= START_ST;
      ns_row_q   <= START_ROW;
      ns_col_q   <= START_COL;
      reward_q   <= '0;
      done_q     <= 1'b0;
      cause_q    <= '0;
      step_q     <= '0;
      epi_q      <= '0;
    end else begin
      fsm_q      <= fsm_d;
      act_q      <= act_d;
      row_q      <= row_d;
      col_q      <= col_d;
      state_q    <= state_d;
      cand_row_q <= cand_row_d;
      cand_col_q <= cand_col_d;
      addr_q     <= addr_d;
      ns_q       <= ns_d;
      ns_row_q   <= ns_row_d;
      ns_col_q   <= ns_col_d;
      reward_q   <= reward_d;
      done_q     <= done_d;
      cause_q    <= cause_d;
      step_q     <= step_d;
      epi_q      <= epi_d;
    end
  end

  assign act_ready     = (fsm_q == IDLE);
  assign map_rd_en     = (fsm_q == READ);
  assign resp_valid    = (fsm_q == RESP);
  assign map_addr      = addr_q;
  assign state         = state_q;
  assign next_state    = ns_q;
  assign reward        = reward_q;
  assign done          = done_q;
  assign done_cause    = cause_q;
  assign step_count    = step_q;
  assign episode_count = epi_q;

endmodule

// File: tb/tb_maze_step_controller.sv
// Directed bench for maze_step_controller. Instance A uses default
// parameters; instance B uses MAX_STEPS=4 for timeout behaviour. A shared
// map model answers whichever instance is selected.
module tb_maze_step_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       act_valid;
  logic [3:0] act;
  logic       sel;
  logic [3:0] map_rd_data = '0;
  logic [3:0] mem [0:127];

  logic        a_ready, a_rd_en, a_resp, a_done;
  logic [6:0]  a_addr, a_state, a_ns;
  logic [7:0]  a_rew, a_step;
  logic [1:0]  a_cause;
  logic [15:0] a_epi;
  logic        b_ready, b_rd_en, b_resp, b_done;
  logic [6:0]  b_addr, b_state, b_ns;
  logic [7:0]  b_rew, b_step;
  logic [1:0]  b_cause;
  logic [15:0] b_epi;

  maze_step_controller dut_a (
    .clk(clk), .rst(rst), .act_valid(act_valid & ~sel), .act_ready(a_ready),
    .act(act), .map_rd_en(a_rd_en), .map_addr(a_addr), .map_rd_data(map_rd_data),
    .resp_valid(a_resp), .state(a_state), .next_state(a_ns), .reward(a_rew),
    .done(a_done), .done_cause(a_cause), .step_count(a_step), .episode_count(a_epi)
  );

  maze_step_controller #(.MAX_STEPS(4)) dut_b (
    .clk(clk), .rst(rst), .act_valid(act_valid & sel), .act_ready(b_ready),
    .act(act), .map_rd_en(b_rd_en), .map_addr(b_addr), .map_rd_data(map_rd_data),
    .resp_valid(b_resp), .state(b_state), .next_state(b_ns), .reward(b_rew),
    .done(b_done), .done_cause(b_cause), .step_count(b_step), .episode_count(b_epi)
  );

  logic        m_ready, m_rd_en, m_resp, m_done;
  logic [6:0]  m_addr, m_state, m_ns;
  logic [7:0]  m_rew, m_step;
  logic [1:0]  m_cause;
  logic [15:0] m_epi;
  assign m_ready = sel ? b_ready : a_ready;
  assign m_rd_en = sel ? b_rd_en : a_rd_en;
  assign m_resp  = sel ? b_resp  : a_resp;
  assign m_done  = sel ? b_done  : a_done;
  assign m_addr  = sel ? b_addr  : a_addr;
  assign m_state = sel ? b_state : a_state;
  assign m_ns    = sel ? b_ns    : a_ns;
  assign m_rew   = sel ? b_rew   : a_rew;
  assign m_step  = sel ? b_step  : a_step;
  assign m_cause = sel ? b_cause : a_cause;
  assign m_epi   = sel ? b_epi   : a_epi;

  // Map memory: one-cycle read latency.
  always @(posedge clk) if (m_rd_en) map_rd_data <= mem[m_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the selected DUT idle; returns at the negedge
  // of the cycle after RESP.
  task automatic do_step(input string nm, input logic [3:0] a, input int exp_lat,
                         input logic [6:0] exp_addr, input logic [6:0] exp_ns,
                         input logic [7:0] exp_rew, input logic exp_done,
                         input logic [1:0] exp_cause, input logic [6:0] exp_state,
                         input logic [7:0] exp_step, input logic [15:0] exp_epi);
    int lat, rd_cnt, rd_lat;
    logic [6:0] rd_addr;
    chk({nm, ".ready"}, m_ready, 1);
    act_valid = 1'b1;
    act       = a;
    @(negedge clk);
    act_valid = 1'b0;
    act       = '0;
    lat = 1; rd_cnt = 0; rd_lat = 0; rd_addr = '0;
    while (!m_resp && lat < 12) begin
      if (m_rd_en) begin
        rd_cnt++;
        rd_lat  = lat;
        rd_addr = m_addr;
      end
      @(negedge clk);
      lat++;
    end
    chk({nm, ".lat"}, lat, exp_lat);
    chk({nm, ".rd_cnt"}, rd_cnt, (exp_lat == 4) ? 1 : 0);
    if (exp_lat == 4) begin
      chk({nm, ".rd_lat"}, rd_lat, 2);
      chk({nm, ".rd_addr"}, rd_addr, exp_addr);
    end
    chk({nm, ".ready_resp"}, m_ready, 0);
    chk({nm, ".next_state"}, m_ns, exp_ns);
    chk({nm, ".reward"}, m_rew, exp_rew);
    chk({nm, ".done"}, m_done, exp_done);
    chk({nm, ".cause"}, m_cause, exp_cause);
    @(negedge clk);
    chk({nm, ".resp_off"}, m_resp, 0);
    chk({nm, ".state"}, m_state, exp_state);
    chk({nm, ".step"}, m_step, exp_step);
    chk({nm, ".episode"}, m_epi, exp_epi);
  endtask

  localparam logic [3:0] UP = 4'b0001, DN = 4'b0010, LF = 4'b0100, RT = 4'b1000;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int unsigned i = 0; i < 128; i++) mem[i] = 4'd0;
    mem[5]  = 4'd1;
    mem[24] = 4'd2;
    rst = 1'b1; act_valid = 1'b0; act = '0; sel = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst.ready", a_ready, 1);
    chk("rst.rd_en", a_rd_en, 0);
    chk("rst.addr", a_addr, 0);
    chk("rst.resp", a_resp, 0);
    chk("rst.state", a_state, 0);
    chk("rst.next_state", a_ns, 0);
    chk("rst.reward", a_rew, 0);
    chk("rst.done", a_done, 0);
    chk("rst.cause", a_cause, 0);
    chk("rst.step", a_step, 0);
    chk("rst.episode", a_epi, 0);

    //       name       act lat addr ns    rew    dn cause st  step epi
    do_step("t1_right", RT, 4, 1,  1,  8'hFF, 0, 0, 1,  1,  0);
    do_step("back_left", LF, 4, 0, 0,  8'hFF, 0, 0, 0,  2,  0);
    do_step("t2_up_oob", UP, 2, 0, 0,  8'hFB, 0, 0, 0,  3,  0);
    do_step("t3_wall",  DN, 4, 5,  0,  8'hFB, 0, 0, 0,  4,  0);
    do_step("p_r1",     RT, 4, 1,  1,  8'hFF, 0, 0, 1,  5,  0);
    do_step("p_d6",     DN, 4, 6,  6,  8'hFF, 0, 0, 6,  6,  0);
    do_step("p_d11",    DN, 4, 11, 11, 8'hFF, 0, 0, 11, 7,  0);
    do_step("p_d16",    DN, 4, 16, 16, 8'hFF, 0, 0, 16, 8,  0);
    do_step("p_d21",    DN, 4, 21, 21, 8'hFF, 0, 0, 21, 9,  0);
    do_step("dn_oob",   DN, 2, 0,  21, 8'hFB, 0, 0, 21, 10, 0);
    do_step("p_r22",    RT, 4, 22, 22, 8'hFF, 0, 0, 22, 11, 0);
    do_step("p_r23",    RT, 4, 23, 23, 8'hFF, 0, 0, 23, 12, 0);
    do_step("t4_goal",  RT, 4, 24, 24, 8'h0A, 1, 1, 0,  0,  1);
    do_step("lf_oob",   LF, 2, 0,  0,  8'hFB, 0, 0, 0,  1,  1);
    do_step("t6_pre",   RT, 4, 1,  1,  8'hFF, 0, 0, 1,  2,  1);

    // Reset asserted while the map read is outstanding.
    act_valid = 1'b1; act = RT;
    @(negedge clk);
    act_valid = 1'b0; act = '0;
    @(negedge clk);
    chk("t6.read", a_rd_en, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6.resp", a_resp, 0);
    chk("t6.ready", a_ready, 1);
    chk("t6.state", a_state, 0);
    chk("t6.step", a_step, 0);
    chk("t6.episode", a_epi, 0);
    chk("t6.rd_en", a_rd_en, 0);
    chk("t6.addr", a_addr, 0);
    chk("t6.next_state", a_ns, 0);
    chk("t6.reward", a_rew, 0);
    @(negedge clk);
    chk("t6.resp_after", a_resp, 0);

    // Timeout with MAX_STEPS=4, then goal on the fourth step of an episode.
    sel = 1'b1;
    mem[1] = 4'd2;
    do_step("t5_s1", 4'b0011, 2, 0, 0, 8'hFB, 0, 0, 0, 1, 0);
    do_step("t5_s2", 4'b0011, 2, 0, 0, 8'hFB, 0, 0, 0, 2, 0);
    do_step("t5_s3", 4'b0011, 2, 0, 0, 8'hFB, 0, 0, 0, 3, 0);
    do_step("t5_s4", 4'b0011, 2, 0, 0, 8'hFB, 1, 3, 0, 0, 1);
    do_step("pr_s1", 4'b0000, 2, 0, 0, 8'hFB, 0, 0, 0, 1, 1);
    do_step("pr_s2", 4'b1100, 2, 0, 0, 8'hFB, 0, 0, 0, 2, 1);
    do_step("pr_s3", UP,      2, 0, 0, 8'hFB, 0, 0, 0, 3, 1);
    do_step("pr_goal", RT,    4, 1, 1, 8'h0A, 1, 1, 0, 0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/maze_step_controller.md
# maze_step_controller

Sequencer for the agent's interaction with the 5x5 maze map memory. It accepts one action at a time from the learning agent and computes the candidate cell with a boundary check. When the candidate is in bounds, it reads that cell's 4-bit code from the map memory, then returns the resulting state, reward, and episode-termination status. It sits between the Q-learning agent and the map storage and owns agent position, step count and episode count.

## Interface
Parameters:
- GRID_W, 5, columns (GRID_W*GRID_H <= 128)
- GRID_H, 5, rows
- START_STATE, 0, state entered on reset and at every episode end
- MAX_STEPS, 50, steps per episode before timeout (1..255)
- R_STEP, -1, reward for move into free cell (8-bit signed)
- R_WALL, -5, reward for wall, out-of-bounds or invalid action
- R_GOAL, 10, reward for entering goal cell
- R_TRAP, -10, reward for entering trap cell

Ports:
- clk  in  1  clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- act_valid  in  1  action offered
- act_ready  out  1  controller can accept action
- act  in  4  one-hot action: bit0 up, bit1 down, bit2 left, bit3 right
- map_rd_en  out  1  map read strobe
- map_addr  out  7  map cell index (row*GRID_W+col)
- map_rd_data  in  4  cell code, valid the cycle after map_rd_en
- resp_valid  out  1  one-cycle pulse: step result valid
- state  out  7  current agent state
- next_state  out  7  resulting state of last step
- reward  out  8  signed reward of last step
- done  out  1  last step ended episode
- done_cause  out  2  0 none, 1 goal, 2 trap, 3 timeout
- step_count  out  8  steps taken in current episode
- episode_count  out  16  completed episodes, wraps at 16'hFFFF

## Operation
- Cell codes: 0 free, 1 wall, 2 goal, 3 trap, 4..15 treated as free.
- Position is held as row and col registers, and state is a registered row*GRID_W+col. The block uses no divider.
- FSM states: IDLE, CHECK, READ, WAIT, RESP.
- IDLE: act_ready=1. On act_valid&act_ready, capture act and go to CHECK.
- CHECK: evaluate the captured action.
  - An action that is not one-hot, or a move off the grid (row 0 up, row GRID_H-1 down, col 0 left, col GRID_W-1 right), gives the result "stay" with R_WALL. Go to RESP with no map read.
  - Otherwise register the candidate address and go to READ.
- READ: map_rd_en=1, map_addr=candidate. Go to WAIT.
- WAIT: capture map_rd_data.
  - Wall: stay, R_WALL.
  - Free: move, R_STEP.
  - Goal: move, R_GOAL, cause 1.
  - Trap: move, R_TRAP, cause 2.
  - Go to RESP.
- RESP: resp_valid=1, with next_state/reward/done/done_cause valid.
  - New step count = step_count+1.
  - If no goal/trap and new count == MAX_STEPS: done=1, cause 3. Goal/trap take precedence over timeout.
  - If done: state<=START_STATE, step_count<=0, episode_count++.
  - Else: state<=next_state, step_count<=new count.
  - Go to IDLE.
- next_state/reward/done/done_cause hold their values until the next RESP.
- map_rd_en is high only in READ. map_addr holds the last candidate otherwise.

## Timing
- Reset values:
  - FSM=IDLE, act_ready=1, map_rd_en=0, map_addr=0, resp_valid=0.
  - state=START_STATE, next_state=START_STATE.
  - reward=0, done=0, done_cause=0, step_count=0, episode_count=0.
- Handshake accepted at edge k. The cycle after k is CHECK.
- In-bounds latency: map_rd_en is high in cycle k+2 and resp_valid is high in cycle k+4.
- Short path (out-of-bounds or invalid action): resp_valid is high in cycle k+2 and map_rd_en is never asserted.
- act_ready=0 from CHECK through RESP. The next action can be accepted in the cycle after RESP.
- state, step_count and episode_count update on the edge ending RESP.
- rst in any state takes effect at the next edge: the FSM returns to IDLE, the pending action is discarded, no resp_valid is emitted and all outputs return to their reset values.

## Test plan
1. After reset, act=4'b1000 with map[1]=0: map_rd_en with addr 1 at k+2, resp at k+4, next_state=1, reward=8'hFF, done=0, step_count=1.
2. At state 0, act=4'b0001 (up): resp at k+2, next_state=0, reward=8'hFB, no map_rd_en pulse, step_count increments.
3. map[5]=1, at state 0, act=4'b0010 (down): one map_rd_en with addr 5, next_state=0, reward=8'hFB.
4. map[24]=2, agent at 23, act=4'b1000: next_state=24, reward=8'h0A, done=1, cause=1. Then state=0, step_count=0, episode_count=1.
5. MAX_STEPS=4, four consecutive act=4'b0011 (invalid): the first three resps have done=0. The fourth has done=1, cause=3, reward=8'hFB. Then state=0 and episode_count=1.
6. rst pulsed during WAIT: no resp_valid, and the following cycle shows act_ready=1, state=0, step_count=0, map_rd_en=0.
